// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage core: PC/pipeline-register holds, bubble requests,
// mul/div occupancy and wrong-path fetch discard. Optional stall counter: PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_is_load_i,
  input  logic              ex_branch_taken_i,
  input  logic              imem_ready_i,
  input  logic              dmem_req_i,
  input  logic              dmem_ready_i,
  input  logic              md_start_i,
  input  logic              md_done_i,
  output logic              pc_gate_o,
  output logic [3:0]        gate_o,
  output logic [3:0]        flush_o
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt_o
`endif
);

  typedef enum logic {RUN, MD_WAIT} state_e;

  state_e state_q, state_d;
  logic   md_done_pend_q, md_done_pend_d;
  logic   drop_pend_q, drop_pend_d;

  logic dmem_stall, ex_stall, redirect, redirect_win, load_use, drop_resp, fetch_wait;
  logic rs1_hit, rs2_hit;

  assign dmem_stall   = dmem_req_i & ~dmem_ready_i;
  assign ex_stall     = (state_q == MD_WAIT) & ~md_done_i & ~md_done_pend_q;
  assign redirect     = ex_branch_taken_i;
  assign redirect_win = redirect & ~dmem_stall & ~ex_stall;
  assign rs1_hit      = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit      = id_use_rs2_i & (id_rs2_i == ex_rd_i);
  assign load_use     = ex_is_load_i & (ex_rd_i != '0) & (rs1_hit | rs2_hit);
  assign drop_resp    = drop_pend_q & imem_ready_i;
  assign fetch_wait   = ~imem_ready_i | drop_resp;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    pc_gate_o = 1'b0;
    gate_o    = 4'b0000;
    flush_o   = 4'b0000;
    if (rst_i) begin
      pc_gate_o = 1'b1;
      flush_o   = 4'b1111;
    end else if (dmem_stall) begin
      pc_gate_o = 1'b1;
      gate_o    = 4'b0111;
      flush_o   = 4'b1000;
    end else if (ex_stall) begin
      pc_gate_o = 1'b1;
      gate_o    = 4'b0011;
      flush_o   = 4'b0100;
    end else if (redirect) begin
      flush_o   = 4'b0011;
    end else if (load_use) begin
      pc_gate_o = 1'b1;
      gate_o    = 4'b0001;
      flush_o   = 4'b0010;
    end else if (fetch_wait) begin
      pc_gate_o = 1'b1;
      flush_o   = 4'b0001;
    end
  end

  always_comb begin
    state_d        = state_q;
    md_done_pend_d = md_done_pend_q;
    drop_pend_d    = drop_pend_q;

    unique case (state_q)
      RUN: begin
        // A start with its result in the same cycle never occupies EX.
        if (md_start_i & ~md_done_i & ~dmem_stall) state_d = MD_WAIT;
      end
      MD_WAIT: begin
        if ((md_done_i | md_done_pend_q) & ~dmem_stall) begin
          state_d        = RUN;
          md_done_pend_d = 1'b0;
        end else if (md_done_i & dmem_stall) begin
          md_done_pend_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    // Only one fetch can be outstanding, so a single flag tracks the wrong-path response.
    if (redirect_win) drop_pend_d = drop_pend_q | ~imem_ready_i;
    else if (drop_resp) drop_pend_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= RUN;
      md_done_pend_q <= 1'b0;
      drop_pend_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      md_done_pend_q <= md_done_pend_d;
      drop_pend_q    <= drop_pend_d;
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  // Fetch-wait cycles (flush of IF/ID) are not counted as stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_gate_o & ~flush_o[0]) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
